// File: rtl/adder_accum_stage.sv
// Streaming accumulation stage: sums a programmed burst of signed operands over a
// valid/ready handshake and presents one registered result with a sticky overflow flag.
module adder_accum_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        len,
    input  logic                    sat_en,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_sum,
    output logic                    out_overflow,
    output logic [CNT_W-1:0]        out_count,
    output logic                    busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        rem_q, rem_d;
    logic                    ovf_q, ovf_d;
    logic                    sat_q, sat_d;

    logic                    in_fire;
    logic                    out_fire;
    logic signed [WIDTH:0]   sum_ext;
    logic                    step_ovf;
    logic signed [WIDTH-1:0] step_res;

    function automatic logic signed [WIDTH-1:0] sat_value(input logic neg);
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Sign-extended sum: the top two bits disagree exactly when both operands share a
    // sign and the WIDTH-bit result does not.
    assign sum_ext  = {acc_q[WIDTH-1], acc_q} + {in_data[WIDTH-1], in_data};
    assign step_ovf = sum_ext[WIDTH] != sum_ext[WIDTH-1];
    assign step_res = (step_ovf && sat_q) ? sat_value(acc_q[WIDTH-1]) : sum_ext[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_fire && (rem_q == CNT_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        ovf_d = ovf_q;
        sat_d = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    rem_d = len;
                    ovf_d = 1'b0;
                    sat_d = sat_en;
                end
            end
            ST_ACCUM: begin
                if (in_fire) begin
                    acc_d = step_res;
                    cnt_d = cnt_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    ovf_d = ovf_q | step_ovf;
                end
            end
            default: ;
        endcase
    end

    // Handshake outputs decode only the registered state, so no input-to-output path exists.
    always_comb begin
        in_ready     = (state_q == ST_ACCUM);
        out_valid    = (state_q == ST_DONE);
        busy         = (state_q != ST_IDLE);
        out_sum      = acc_q;
        out_overflow = ovf_q;
        out_count    = cnt_q;
    end

endmodule

// File: tb/tb_adder_accum_stage.sv
// Bench for adder_accum_stage: directed bursts from the test plan plus randomized bursts
// checked against an integer-arithmetic reference model.
module tb_adder_accum_stage;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [7:0]         len;
    logic               sat_en;
    logic               in_valid;
    logic signed [31:0] in_data;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_sum;
    logic               out_overflow;
    logic [7:0]         out_count;
    logic               busy;

    int checks;
    int failures;
    logic [31:0] ops_q[$];

    adder_accum_stage #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .sat_en(sat_en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_overflow(out_overflow), .out_count(out_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer sum per step, clamped or wrapped when outside 32-bit range.
    function automatic void model(input int n, input bit sat, output logic [31:0] s, output bit o);
        longint acc;
        longint t;
        acc = 0;
        o = 0;
        for (int i = 0; i < n; i++) begin
            t = acc + longint'($signed(ops_q[i]));
            if (t > 64'sd2147483647) begin
                o = 1;
                t = sat ? 64'sd2147483647 : t - 64'sd4294967296;
            end else if (t < -64'sd2147483648) begin
                o = 1;
                t = sat ? -64'sd2147483648 : t + 64'sd4294967296;
            end
            acc = t;
        end
        s = acc[31:0];
    endfunction

    task automatic do_burst(input int n, input bit sat, input bit toggle, input int stall,
                            input bit start_in_stall,
                            output logic [31:0] s, output logic o, output logic [7:0] c,
                            output bit lat_ok, output bit stable, output bit saw_rdy,
                            output bit tmo);
        int idx;
        int cyc;
        bit hs;
        idx = 0;
        cyc = 0;
        tmo = 0;
        stable = 1;
        saw_rdy = 0;
        start = 1'b1;
        len = n[7:0];
        sat_en = sat;
        step();
        start = 1'b0;
        while (idx < n && !tmo) begin
            in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            in_data = ops_q[idx];
            if (in_ready) saw_rdy = 1;
            hs = in_valid && in_ready;
            step();
            if (hs) idx++;
            cyc++;
            if (cyc > 500) tmo = 1;
        end
        in_valid = 1'b0;
        in_data = $urandom;
        if (in_ready) saw_rdy = 1;
        lat_ok = out_valid;
        s = out_sum;
        o = out_overflow;
        c = out_count;
        for (int k = 0; k < stall; k++) begin
            if (start_in_stall) begin
                start = 1'b1;
                len = 8'd5;
            end
            if (!out_valid || out_sum !== s || out_count !== c || out_overflow !== o || in_ready)
                stable = 0;
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({out_valid, in_ready, busy, out_overflow} !== 4'b0 || out_sum !== 32'sd0 || out_count !== 8'd0) begin
            failures++;
            $display("FAIL reset: valid=%b rdy=%b busy=%b ovf=%b sum=%0d cnt=%0d, required all 0",
                     out_valid, in_ready, busy, out_overflow, out_sum, out_count);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [31:0] s; logic o; logic [7:0] c; bit lat, st, rdy, tmo;
        ops_q = '{32'd10, 32'd15};
        do_burst(2, 0, 0, 0, 0, s, o, c, lat, st, rdy, tmo);
        checks++;
        if (s !== 32'd25 || o !== 1'b0 || c !== 8'd2 || tmo) begin
            failures++;
            $display("FAIL basic: sum=%0d ovf=%b cnt=%0d tmo=%b, required 25 0 2 0", s, o, c, tmo);
        end
        checks++;
        if (!lat) begin
            failures++;
            $display("FAIL basic_latency: out_valid=%b after last handshake, required 1", lat);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 32'sd25) begin
            failures++;
            $display("FAIL basic_release: valid=%b busy=%b sum=%0d, required 0 0 25", out_valid, busy, out_sum);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] s; logic o; logic [7:0] c; bit lat, st, rdy, tmo;
        ops_q = '{32'h7FFFFFFF, 32'h7FFFFFFF};
        do_burst(2, 0, 0, 0, 0, s, o, c, lat, st, rdy, tmo);
        checks++;
        if (s !== 32'hFFFFFFFE || o !== 1'b1) begin
            failures++;
            $display("FAIL pos_wrap: sum=%h ovf=%b, required fffffffe 1", s, o);
        end
        do_burst(2, 1, 0, 0, 0, s, o, c, lat, st, rdy, tmo);
        checks++;
        if (s !== 32'h7FFFFFFF || o !== 1'b1) begin
            failures++;
            $display("FAIL pos_sat: sum=%h ovf=%b, required 7fffffff 1", s, o);
        end
        ops_q = '{32'h80000000, 32'h80000000};
        do_burst(2, 1, 0, 0, 0, s, o, c, lat, st, rdy, tmo);
        checks++;
        if (s !== 32'h80000000 || o !== 1'b1) begin
            failures++;
            $display("FAIL neg_sat: sum=%h ovf=%b, required 80000000 1", s, o);
        end
        ops_q = '{32'hAAAAAAAA, 32'h55555555, 32'h0};
        do_burst(3, 0, 0, 0, 0, s, o, c, lat, st, rdy, tmo);
        checks++;
        if (s !== 32'hFFFFFFFF || o !== 1'b0 || c !== 8'd3) begin
            failures++;
            $display("FAIL mixed_sign: sum=%h ovf=%b cnt=%0d, required ffffffff 0 3", s, o, c);
        end
    endtask

    task automatic test_stall();
        logic [31:0] s; logic o; logic [7:0] c; bit lat, st, rdy, tmo;
        ops_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_burst(4, 0, 1, 5, 1, s, o, c, lat, st, rdy, tmo);
        checks++;
        if (s !== 32'd10 || c !== 8'd4 || o !== 1'b0 || !lat || tmo) begin
            failures++;
            $display("FAIL stall_result: sum=%0d cnt=%0d ovf=%b lat=%b tmo=%b, required 10 4 0 1 0",
                     s, c, o, lat, tmo);
        end
        checks++;
        if (!st) begin
            failures++;
            $display("FAIL stall_hold: outputs changed during out_ready=0, required stable");
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== 32'sd10 || out_count !== 8'd4) begin
            failures++;
            $display("FAIL stall_start_ignored: busy=%b valid=%b sum=%0d cnt=%0d, required 0 0 10 4",
                     busy, out_valid, out_sum, out_count);
        end
    endtask

    task automatic test_len0();
        logic [31:0] s; logic o; logic [7:0] c; bit lat, st, rdy, tmo;
        ops_q = '{};
        do_burst(0, 0, 0, 2, 0, s, o, c, lat, st, rdy, tmo);
        checks++;
        if (!lat || s !== 32'd0 || c !== 8'd0 || o !== 1'b0 || rdy || !st) begin
            failures++;
            $display("FAIL len0: valid=%b sum=%0d cnt=%0d ovf=%b rdy_seen=%b stable=%b, required 1 0 0 0 0 1",
                     lat, s, c, o, rdy, st);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] s; logic o; logic [7:0] c; bit lat, st, rdy, tmo;
        bit seen_valid;
        start = 1'b1; len = 8'd3; sat_en = 1'b0;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'sd7;
        step();
        in_data = 32'sd9;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({out_valid, in_ready, busy, out_overflow} !== 4'b0 || out_sum !== 32'sd0 || out_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid: valid=%b rdy=%b busy=%b ovf=%b sum=%0d cnt=%0d, required all 0",
                     out_valid, in_ready, busy, out_overflow, out_sum, out_count);
        end
        seen_valid = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid || busy) seen_valid = 1;
            step();
        end
        checks++;
        if (seen_valid) begin
            failures++;
            $display("FAIL reset_mid_no_result: out_valid/busy seen=1, required 0");
        end
        ops_q = '{32'hFFFFFFF6};
        do_burst(1, 0, 0, 0, 0, s, o, c, lat, st, rdy, tmo);
        checks++;
        if (s !== 32'hFFFFFFF6 || c !== 8'd1 || o !== 1'b0) begin
            failures++;
            $display("FAIL fresh_burst: sum=%0d cnt=%0d ovf=%b, required -10 1 0", $signed(s), c, o);
        end
    endtask

    task automatic test_random();
        logic [31:0] s; logic o; logic [7:0] c; bit lat, st, rdy, tmo;
        logic [31:0] es; bit eo;
        int n;
        bit sat;
        for (int b = 0; b < 24; b++) begin
            n = $urandom_range(1, 9);
            sat = $urandom_range(0, 1);
            ops_q = '{};
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0: ops_q.push_back(32'h7FFFFFFF - $urandom_range(0, 3));
                    1: ops_q.push_back(32'h80000000 + $urandom_range(0, 3));
                    default: ops_q.push_back($urandom);
                endcase
            end
            model(n, sat, es, eo);
            do_burst(n, sat, $urandom_range(0, 1), $urandom_range(0, 3), 0, s, o, c, lat, st, rdy, tmo);
            checks++;
            if (s !== es || o !== eo || c !== n[7:0] || !lat || !st || tmo) begin
                failures++;
                $display("FAIL random_%0d: sum=%h ovf=%b cnt=%0d lat=%b stable=%b tmo=%b, required %h %b %0d 1 1 0",
                         b, s, o, c, lat, st, tmo, es, eo, n);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        len = 8'd0;
        sat_en = 1'b0;
        in_valid = 1'b0;
        in_data = 32'sd0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_stall();
        test_len0();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
